// File: rtl/code_checker.sv
// rtl/code_checker.sv - keypad code compare and arm/unlock/lockout/alarm controller
module code_checker #(
    parameter int MAX_ATTEMPTS   = 3,
    parameter int UNLOCK_CYCLES  = 8,
    parameter int LOCKOUT_CYCLES = 16,
    localparam int CW   = $clog2(MAX_ATTEMPTS + 1),
    localparam int TMAX = (UNLOCK_CYCLES > LOCKOUT_CYCLES) ? UNLOCK_CYCLES : LOCKOUT_CYCLES,
    localparam int TW   = $clog2(TMAX + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [3:0]    stored_code,
    input  logic [3:0]    entry,
    input  logic          entry_valid,
    input  logic          sensor,
    output logic          unlock,
    output logic          alarm,
    output logic          locked_out,
    output logic          match_pulse,
    output logic          fail_pulse,
    output logic [CW-1:0] fail_count,
    output logic [1:0]    state
);

    typedef enum logic [1:0] {
        ARMED    = 2'd0,
        UNLOCKED = 2'd1,
        LOCKOUT  = 2'd2,
        ALARM    = 2'd3
    } state_t;

    localparam logic [TW-1:0] UNLOCK_LOAD  = TW'(UNLOCK_CYCLES - 1);
    localparam logic [TW-1:0] LOCKOUT_LOAD = TW'(LOCKOUT_CYCLES - 1);
    localparam logic [CW-1:0] LAST_TRY     = CW'(MAX_ATTEMPTS - 1);
    localparam logic [CW-1:0] MAX_COUNT    = CW'(MAX_ATTEMPTS);

    state_t        cur, nxt;
    logic [TW-1:0] timer, timer_nxt;
    logic [CW-1:0] fc, fc_nxt;
    logic          mp_nxt, fp_nxt;
    logic          hit, miss;

    assign hit  = entry_valid && (entry == stored_code);
    assign miss = entry_valid && (entry != stored_code);

    always_ff @(posedge clk) begin
        if (rst) begin
            cur         <= ARMED;
            timer       <= '0;
            fc          <= '0;
            unlock      <= 1'b0;
            alarm       <= 1'b0;
            locked_out  <= 1'b0;
            match_pulse <= 1'b0;
            fail_pulse  <= 1'b0;
        end else begin
            cur         <= nxt;
            timer       <= timer_nxt;
            fc          <= fc_nxt;
            unlock      <= (nxt == UNLOCKED);
            alarm       <= (nxt == ALARM);
            locked_out  <= (nxt == LOCKOUT);
            match_pulse <= mp_nxt;
            fail_pulse  <= fp_nxt;
        end
    end

    always_comb begin
        nxt       = cur;
        timer_nxt = timer;
        fc_nxt    = fc;
        mp_nxt    = 1'b0;
        fp_nxt    = 1'b0;
        case (cur)
            ARMED: begin
                // correct entry beats sensor, sensor beats a wrong entry
                if (hit) begin
                    nxt       = UNLOCKED;
                    mp_nxt    = 1'b1;
                    fc_nxt    = '0;
                    timer_nxt = UNLOCK_LOAD;
                end else if (sensor) begin
                    nxt    = ALARM;
                    fp_nxt = miss;
                end else if (miss) begin
                    fp_nxt = 1'b1;
                    if (fc == LAST_TRY) begin
                        nxt       = LOCKOUT;
                        fc_nxt    = MAX_COUNT;
                        timer_nxt = LOCKOUT_LOAD;
                    end else begin
                        fc_nxt = fc + 1'b1;
                    end
                end
            end
            UNLOCKED: begin
                if (timer == '0) begin
                    nxt = ARMED;
                end else begin
                    timer_nxt = timer - 1'b1;
                end
            end
            LOCKOUT: begin
                if (sensor) begin
                    nxt = ALARM;
                end else if (timer == '0) begin
                    nxt    = ARMED;
                    fc_nxt = '0;
                end else begin
                    timer_nxt = timer - 1'b1;
                end
            end
            ALARM: begin
                if (hit) begin
                    nxt    = ARMED;
                    mp_nxt = 1'b1;
                    fc_nxt = '0;
                end else if (miss) begin
                    fp_nxt = 1'b1;
                end
            end
            default: nxt = ARMED;
        endcase
    end

    assign fail_count = fc;
    assign state      = cur;

endmodule

// File: tb/tb_code_checker.sv
// tb/tb_code_checker.sv - table, directed and randomized checks of code_checker
module tb_code_checker;

    localparam int MAXA = 3;
    localparam int UC   = 8;
    localparam int LC   = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] stored_code, entry;
    logic       entry_valid, sensor;
    logic       unlock, alarm, locked_out, match_pulse, fail_pulse;
    logic [1:0] fail_count;
    logic [1:0] state;

    code_checker #(.MAX_ATTEMPTS(MAXA), .UNLOCK_CYCLES(UC), .LOCKOUT_CYCLES(LC)) dut (
        .clk(clk), .rst(rst), .stored_code(stored_code), .entry(entry),
        .entry_valid(entry_valid), .sensor(sensor), .unlock(unlock), .alarm(alarm),
        .locked_out(locked_out), .match_pulse(match_pulse), .fail_pulse(fail_pulse),
        .fail_count(fail_count), .state(state)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference: mode 0..3 as ARMED/UNLOCKED/LOCKOUT/ALARM, m_left = visible cycles still owed
    int m_mode = 0, m_left = 0, m_fc = 0;
    bit m_mp = 0, m_fp = 0;

    task automatic model_step(input bit r, input bit [3:0] code, input bit [3:0] ent,
                              input bit ev, input bit sen);
        bit ok, bad;
        ok   = ev && (ent == code);
        bad  = ev && (ent != code);
        m_mp = 0;
        m_fp = 0;
        if (r) begin
            m_mode = 0; m_left = 0; m_fc = 0;
            return;
        end
        case (m_mode)
            0: if (ok) begin
                   m_mp = 1; m_fc = 0; m_mode = 1; m_left = UC;
               end else if (sen) begin
                   m_fp = bad; m_mode = 3;
               end else if (bad) begin
                   m_fp = 1; m_fc = m_fc + 1;
                   if (m_fc == MAXA) begin m_mode = 2; m_left = LC; end
               end
            1: begin
                   m_left = m_left - 1;
                   if (m_left == 0) m_mode = 0;
               end
            2: if (sen) m_mode = 3;
               else begin
                   m_left = m_left - 1;
                   if (m_left == 0) begin m_mode = 0; m_fc = 0; end
               end
            default: if (ok) begin
                         m_mode = 0; m_mp = 1; m_fc = 0;
                     end else if (bad) m_fp = 1;
        endcase
    endtask

    function automatic logic [8:0] act_vec();
        return {state, fail_count, unlock, alarm, locked_out, match_pulse, fail_pulse};
    endfunction

    task automatic check_eq(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic apply(input bit r, input bit [3:0] code, input bit [3:0] ent,
                         input bit ev, input bit sen);
        rst = r; stored_code = code; entry = ent; entry_valid = ev; sensor = sen;
        @(posedge clk);
        model_step(r, code, ent, ev, sen);
        #1;
    endtask

    task automatic cyc(input string name, input bit r, input bit [3:0] code,
                       input bit [3:0] ent, input bit ev, input bit sen);
        logic [8:0] exp;
        apply(r, code, ent, ev, sen);
        exp = {2'(m_mode), 2'(m_fc), 1'(m_mode == 1), 1'(m_mode == 3), 1'(m_mode == 2),
               1'(m_mp), 1'(m_fp)};
        check_eq(name, int'(act_vec()), int'(exp));
    endtask

    typedef struct {
        bit       r;
        bit [3:0] code;
        bit [3:0] ent;
        bit       ev;
        bit       sen;
        bit [8:0] exp;   // {state, fail_count, unlock, alarm, locked_out, match, fail}
    } vec_t;

    vec_t tbl[17];
    int   n;

    initial begin
        tbl[0]  = '{1, 4'h0, 4'h0, 0, 0, {2'd0, 2'd0, 5'b00000}};
        tbl[1]  = '{0, 4'hA, 4'hA, 1, 0, {2'd1, 2'd0, 5'b10010}};
        tbl[2]  = '{0, 4'hA, 4'h0, 0, 0, {2'd1, 2'd0, 5'b10000}};
        tbl[3]  = '{1, 4'hA, 4'h0, 0, 0, {2'd0, 2'd0, 5'b00000}};
        tbl[4]  = '{0, 4'h5, 4'h1, 1, 0, {2'd0, 2'd1, 5'b00001}};
        tbl[5]  = '{0, 4'h5, 4'h2, 1, 1, {2'd3, 2'd1, 5'b01001}};
        tbl[6]  = '{0, 4'h5, 4'h0, 1, 0, {2'd3, 2'd1, 5'b01001}};
        tbl[7]  = '{0, 4'h5, 4'h0, 0, 1, {2'd3, 2'd1, 5'b01000}};
        tbl[8]  = '{0, 4'h5, 4'h5, 1, 0, {2'd0, 2'd0, 5'b00010}};
        tbl[9]  = '{0, 4'h5, 4'h5, 1, 1, {2'd1, 2'd0, 5'b10010}};
        tbl[10] = '{1, 4'h5, 4'h0, 0, 0, {2'd0, 2'd0, 5'b00000}};
        tbl[11] = '{0, 4'h5, 4'h3, 1, 0, {2'd0, 2'd1, 5'b00001}};
        tbl[12] = '{0, 4'h5, 4'h3, 1, 0, {2'd0, 2'd2, 5'b00001}};
        tbl[13] = '{0, 4'h5, 4'h3, 1, 0, {2'd2, 2'd3, 5'b00101}};
        tbl[14] = '{0, 4'h5, 4'h5, 1, 0, {2'd2, 2'd3, 5'b00100}};
        tbl[15] = '{0, 4'h5, 4'h0, 0, 1, {2'd3, 2'd3, 5'b01000}};
        tbl[16] = '{1, 4'h5, 4'h0, 0, 0, {2'd0, 2'd0, 5'b00000}};

        for (int i = 0; i < 17; i++) begin
            apply(tbl[i].r, tbl[i].code, tbl[i].ent, tbl[i].ev, tbl[i].sen);
            check_eq($sformatf("table_row%0d", i), int'(act_vec()), int'(tbl[i].exp));
        end

        // correct entry: unlock held exactly UC cycles
        cyc("t1_reset", 1, 4'hA, 4'h0, 0, 0);
        cyc("t1_match", 0, 4'hA, 4'hA, 1, 0);
        n = unlock ? 1 : 0;
        for (int i = 0; i < 40 && unlock; i++) begin
            cyc("t1_hold", 0, 4'hA, 4'h0, 0, 0);
            if (unlock) n++;
        end
        check_eq("t1_unlock_len", n, UC);
        check_eq("t1_fc_after", int'(fail_count), 0);

        // three wrong entries -> lockout of LC cycles, entry ignored inside it
        cyc("t2_w1", 0, 4'h5, 4'h1, 1, 0);
        cyc("t2_w2", 0, 4'h5, 4'h2, 1, 0);
        cyc("t2_w3", 0, 4'h5, 4'h3, 1, 0);
        n = locked_out ? 1 : 0;
        for (int i = 0; i < 40 && locked_out; i++) begin
            cyc("t2_lock", 0, 4'h5, 4'h5, (i == 2), 0);
            if (locked_out) n++;
        end
        check_eq("t2_lock_len", n, LC);
        check_eq("t2_state_after", int'(state), 0);
        check_eq("t2_fc_after", int'(fail_count), 0);

        // reset on cycle 3 of unlock
        cyc("t5_match", 0, 4'h7, 4'h7, 1, 0);
        cyc("t5_u2", 0, 4'h7, 4'h0, 0, 0);
        cyc("t5_u3", 0, 4'h7, 4'h0, 0, 0);
        cyc("t5_rst_u", 1, 4'h7, 4'h0, 0, 0);
        check_eq("t5_zero_after_unlock_rst", int'(act_vec()), 0);

        // reset on cycle 5 of lockout
        for (int i = 0; i < 3; i++) cyc("t5_wrong", 0, 4'h7, 4'h1, 1, 0);
        for (int i = 0; i < 4; i++) cyc("t5_lock", 0, 4'h7, 4'h0, 0, 0);
        cyc("t5_rst_l", 1, 4'h7, 4'h0, 0, 0);
        check_eq("t5_zero_after_lock_rst", int'(act_vec()), 0);

        // entry_valid held high with a wrong code: each cycle is an entry
        n = 0;
        for (int i = 0; i < 3; i++) begin
            cyc("t6_held", 0, 4'h9, 4'h4, 1, 0);
            if (fail_pulse) n++;
        end
        check_eq("t6_fail_pulses", n, 3);
        check_eq("t6_lockout", int'(locked_out), 1);
        cyc("t6_rst", 1, 4'h9, 4'h0, 0, 0);

        // randomized run against the reference
        begin
            logic [3:0] code;
            logic [3:0] ent;
            code = 4'(($urandom));
            for (int i = 0; i < 3000; i++) begin
                if ($urandom_range(0, 31) == 0) code = 4'($urandom);
                ent = ($urandom_range(0, 2) == 0) ? code : 4'($urandom);
                cyc("rand", ($urandom_range(0, 127) == 0), code, ent,
                    ($urandom_range(0, 2) == 0), ($urandom_range(0, 9) == 0));
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/code_checker.md
Name: code_checker

Overview:
Downstream consumer of the 4-bit stored-code register. Compares each keypad entry against the stored code and runs the arm/unlock/lockout/alarm state machine of the home security system. Drives the door-unlock strobe, alarm, and lockout indicators. Keeps a failed-attempt counter.

Parameters:
MAX_ATTEMPTS, 3, consecutive wrong entries in ARMED that trigger LOCKOUT (>=1)
UNLOCK_CYCLES, 8, cycles unlock is held high after a correct entry (>=1)
LOCKOUT_CYCLES, 16, cycles spent in LOCKOUT before returning to ARMED (>=1)

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous, active-high reset
stored_code  input  4  code held by the code register (Q)
entry  input  4  keypad digit/code under test
entry_valid  input  1  1-cycle strobe: entry is valid this cycle
sensor  input  1  intrusion sensor, level, active-high
unlock  output  1  door unlock, high for exactly UNLOCK_CYCLES cycles
alarm  output  1  high while in ALARM
locked_out  output  1  high while in LOCKOUT
match_pulse  output  1  1-cycle pulse: a sampled entry matched
fail_pulse  output  1  1-cycle pulse: a sampled entry mismatched
fail_count  output  CW=$clog2(MAX_ATTEMPTS+1)  consecutive wrong entries in ARMED
state  output  2  ARMED=0, UNLOCKED=1, LOCKOUT=2, ALARM=3 (debug)

Behaviour:
- One clock domain, reset is synchronous and active-high: rst sampled high at an edge -> state=ARMED, fail_count=0, timer=0, all outputs 0 from the next cycle. rst overrides every other input, including mid-unlock, mid-lockout, and in ALARM.
- All outputs are registered. An input sampled at edge k is reflected in outputs after edge k (1-cycle latency).
- Match is exact 4-bit equality of entry and stored_code, using stored_code as sampled at that edge.
- entry_valid is evaluated only in ARMED and ALARM. In UNLOCKED and LOCKOUT it is ignored: no pulses, no count change.
- ARMED, entry_valid and match -> UNLOCKED. match_pulse=1, fail_count=0, unlock=1, timer loaded with UNLOCK_CYCLES-1.
- ARMED, entry_valid and mismatch -> fail_pulse=1, fail_count+1.
  - If the new count equals MAX_ATTEMPTS: -> LOCKOUT, locked_out=1, timer loaded with LOCKOUT_CYCLES-1, fail_count holds at MAX_ATTEMPTS.
- ARMED, sensor=1 with no valid matching entry -> ALARM. Priority is correct entry > sensor > wrong entry.
  - Sensor together with a wrong entry: fail_pulse=1, fail_count unchanged, go to ALARM.
- UNLOCKED: sensor ignored. Timer decrements each cycle. At timer==0, next state is ARMED and unlock drops, so unlock is high exactly UNLOCK_CYCLES cycles.
- LOCKOUT: locked_out=1, timer decrements. sensor=1 -> ALARM immediately and locked_out drops. At timer==0 -> ARMED, fail_count=0.
- ALARM: alarm=1 until a matching entry.
  - Matching entry -> ARMED, alarm=0, match_pulse=1, fail_count=0. No unlock on disarm.
  - Wrong entry -> fail_pulse=1, stay in ALARM, fail_count unchanged.
  - sensor has no effect in ALARM.
- Pulse outputs are high for one cycle only, even if entry_valid is held high. Each high cycle of entry_valid counts as a separate entry.
- stored_code changing mid-operation does not affect state. Only later comparisons use the new value.
- Timer width is $clog2(max(UNLOCK_CYCLES,LOCKOUT_CYCLES)+1). The timer never wraps and is only loaded on state entry.

Test Plan:
1. Reset, then stored_code=4'hA, entry=4'hA with entry_valid for 1 cycle -> match_pulse 1 cycle, unlock high exactly 8 cycles, then state=ARMED, fail_count=0.
2. stored_code=4'h5, wrong entries 4'h1, 4'h2 -> fail_count 1, then 2, fail_pulse each time. Third wrong entry 4'h3 -> locked_out high 16 cycles. An entry 4'h5 during lockout is ignored. Afterwards state=ARMED, fail_count=0.
3. ARMED, sensor=1 -> alarm next cycle. Wrong entry 4'h0 -> fail_pulse, alarm stays. Correct entry -> alarm=0, match_pulse, unlock stays 0, state=ARMED.
4. Same cycle: sensor=1 and correct entry -> UNLOCKED, no alarm. Same cycle: sensor=1 and wrong entry -> ALARM, fail_pulse, fail_count unchanged.
5. rst asserted at cycle 3 of unlock, and separately at cycle 5 of lockout -> next cycle all outputs 0, state=ARMED, fail_count=0.
6. entry_valid held high 3 cycles with a wrong code in ARMED -> 3 fail_pulses, fail_count reaches 3, LOCKOUT entered after the third.
